branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- EX-stage counterpart of the IF-stage 2-bit branch predictor.
- Records each prediction issued at IF in an in-flight queue. When the branch resolves in EX, compares the actual outcome with the predicted direction.
- Drives the outcome bit (history) back to the predictor FSM. On a misprediction, raises redirect/flush to the front end.
- Keeps saturating branch/mispredict statistics.

Parameters:
- DEPTH, 4, number of in-flight predictions tracked; power of 2, ≥ 2.
- FLUSH_CYCLES, 2, cycles flush is held after a mispredict; range 1..7.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- pred_valid  in  1  IF has a conditional branch this cycle (predictor branch flag).
- pred_taken  in  2  predictor state; bit[1]=1 means predicted taken.
- pred_pc  in  32  PC of the predicted branch.
- res_valid  in  1  EX resolves the oldest branch this cycle.
- res_taken  in  1  actual branch outcome.
- res_pc  in  32  PC of the resolving branch.
- res_target  in  32  computed taken target.
- history  out  1  registered actual outcome, fed to the predictor.
- hist_valid  out  1  one-cycle pulse: history is fresh; the predictor update is gated by this.
- mispredict  out  1  one-cycle pulse on a detected mispredict or desync.
- redirect_pc  out  32  correct fetch PC; valid while mispredict=1.
- flush  out  1  squash IF/ID; held FLUSH_CYCLES cycles.
- q_full  out  1  queue holds DEPTH entries; IF must stall on a further branch.
- q_empty  out  1  queue holds 0 entries.
- err  out  1  sticky: underflow or PC desync seen.
- br_cnt  out  CNT_W  resolved branches, saturating.
- miss_cnt  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (rst=0 at an edge):
  - queue emptied, pointers 0, FSM=RUN.
  - all outputs 0, except q_empty=1.
  - applies mid-flush too: flush drops on the next cycle.
- Queue:
  - circular FIFO of {pred_dir=pred_taken[1], pred_pc}, with log2(DEPTH)+1-bit pointers so full and empty are distinguished.
  - Enqueue when pred_valid & !q_full & state==RUN & !miss_now. If pred_valid & q_full, the entry is dropped and err is unaffected; stalling is the front end's job.
  - Dequeue when res_valid & !q_empty & state==RUN.
  - Enqueue and dequeue in the same cycle are legal, including when full; the count is unchanged.
- Resolve (state==RUN, res_valid=1):
  - If q_empty: underflow. err<=1; history/hist_valid are still emitted; no mispredict.
  - Otherwise: miss_now = (head.pred_dir != res_taken) | (head.pred_pc != res_pc).
  - Next cycle: history<=res_taken, hist_valid<=1, br_cnt+1 (saturating at all-ones).
  - If miss_now, also next cycle:
    - mispredict<=1; miss_cnt+1 (saturating).
    - redirect_pc <= res_taken ? res_target : res_pc+4 (32-bit wraparound).
    - whole queue cleared (younger entries are wrong-path).
    - err<=1 additionally if the PC compare failed.
    - FSM -> FLUSH.
- FSM:
  - RUN: normal operation.
  - FLUSH:
    - flush=1; down-counter loaded with FLUSH_CYCLES-1.
    - pred_valid and res_valid ignored (wrong-path).
    - returns to RUN when the counter reaches 0.
  - Latency: flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after the resolving edge.
  - mispredict and hist_valid pulse for 1 cycle only.
- history holds its last value between pulses.
- redirect_pc holds until the next mispredict.

Decomposition:
- Shared package bp_pkg:
  - 2-bit predictor state constants (N=00, n=01, t=10, T=11).
  - OPC_BRANCH=7'b1100011.
  - FSM state encoding RUN/FLUSH.
  - Queue entry struct {pred_dir, pred_pc}.
- One natural sub-module: bp_fifo (parameterised DEPTH×33-bit sync FIFO with synchronous clear). Resolver logic and counters stay in the top.

Test Plan:
- Correct prediction: enqueue pc=0x100 with pred_taken=11; 3 cycles later res_valid, res_taken=1, res_pc=0x100 -> next cycle hist_valid=1, history=1, mispredict=0, br_cnt=1, q_empty=1.
- Mispredict not-taken: enqueue 0x200 (pred_taken=01) and 0x204; resolve 0x200 with res_taken=1, res_target=0x400 -> mispredict pulse, redirect_pc=0x400, flush high 2 cycles, queue empty, miss_cnt=1; pred_valid during flush is not enqueued.
- Mispredict taken: enqueue 0x300 with pred_taken=10; resolve res_taken=0 -> redirect_pc=0x304.
- Full and simultaneous events:
  - enqueue 4 branches -> q_full=1; a 5th pred_valid is dropped.
  - the same cycle as a res_valid with a matching head plus a new pred_valid -> count stays 4, FIFO order preserved on the next 4 resolves.
- Errors: res_valid on empty queue -> err=1, hist_valid=1, no flush. Head pc 0x500 vs res_pc 0x504 -> mispredict, err=1.
- Reset and saturation:
  - rst=0 during the 2nd flush cycle -> next cycle flush=0, q_empty=1, counters 0.
  - with CNT_W=4, 17 resolves -> br_cnt=15.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the EX-stage branch resolver and its in-flight queue.
package bp_pkg;

   // 2-bit predictor states: strongly/weakly not-taken, weakly/strongly taken
   localparam logic [1:0] BP_SN = 2'b00;
   localparam logic [1:0] BP_WN = 2'b01;
   localparam logic [1:0] BP_WT = 2'b10;
   localparam logic [1:0] BP_ST = 2'b11;

   // RV32 conditional-branch opcode, shared with the IF-stage predictor
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } br_state_e;

   typedef struct packed {
      logic        pred_dir;
      logic [31:0] pred_pc;
   } q_entry_t;

   localparam int unsigned Q_ENTRY_W = $bits(q_entry_t);

   // Predicted direction is the MSB of the 2-bit counter (taken half of the range)
   function automatic logic pred_is_taken(input logic [1:0] state);
      return (state == BP_WT) || (state == BP_ST);
   endfunction

endpackage

// File: rtl/bp_fifo.sv
// In-flight prediction queue: circular FIFO with an extra wrap bit on each
// pointer so full and empty are distinguishable, plus a synchronous clear
// used to drop wrong-path entries after a mispredict.
module bp_fifo
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     clr_i,
   input  logic     wr_en_i,
   input  q_entry_t wr_data_i,
   input  logic     rd_en_i,
   output q_entry_t rd_data_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   q_entry_t    mem_q [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic [AW:0] wr_ptr_d;
   logic [AW:0] rd_ptr_d;

   // Pointer next-state: clear wins over any access in the same cycle
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // Pointer registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; when full with a simultaneous read, the slot written is the one
   // being read this cycle, which is safe because the head is read combinationally
   always_ff @(posedge clk) begin
      if (rst && wr_en_i && !clr_i) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: matches each resolving branch against the oldest
// in-flight prediction, feeds the outcome back to the predictor, redirects and
// flushes the front end on a mispredict, and keeps saturating statistics.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal operation; predictions queued, resolutions checked
// FLUSH | wrong-path squash; flush held, pred/res inputs ignored
module branch_resolver
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pred_valid,
   input  logic [1:0]       pred_taken,
   input  logic [31:0]      pred_pc,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [31:0]      res_pc,
   input  logic [31:0]      res_target,
   output logic             history,
   output logic             hist_valid,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic             flush,
   output logic             q_full,
   output logic             q_empty,
   output logic             err,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   br_state_e        state_q;
   logic [2:0]       fcnt_q;
   logic             flush_q;
   logic             history_q;
   logic             hist_valid_q;
   logic             mispredict_q;
   logic [31:0]      redirect_q;
   logic [31:0]      redirect_d;
   logic             err_q;
   logic [CNT_W-1:0] br_cnt_q;
   logic [CNT_W-1:0] br_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q;
   logic [CNT_W-1:0] miss_cnt_d;

   q_entry_t head;
   q_entry_t new_entry;
   logic     run;
   logic     deq;
   logic     enq;
   logic     underflow;
   logic     pc_bad;
   logic     dir_bad;
   logic     miss_now;

   assign run       = (state_q == ST_RUN);
   assign deq       = run && res_valid && !q_empty;
   assign underflow = run && res_valid && q_empty;
   assign pc_bad    = deq && (head.pred_pc != res_pc);
   assign dir_bad   = deq && (head.pred_dir != res_taken);
   assign miss_now  = pc_bad || dir_bad;
   // A full queue may still accept a branch when the head leaves in the same cycle
   assign enq       = run && pred_valid && !miss_now && (!q_full || deq);
   assign new_entry = '{pred_dir: pred_is_taken(pred_taken), pred_pc: pred_pc};

   bp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (miss_now),
      .wr_en_i   (enq),
      .wr_data_i (new_entry),
      .rd_en_i   (deq),
      .rd_data_o (head),
      .full_o    (q_full),
      .empty_o   (q_empty)
   );

   // Saturating counter increments and the corrected fetch address
   always_comb begin
      br_cnt_d   = (br_cnt_q == '1) ? br_cnt_q : br_cnt_q + 1'b1;
      miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
      redirect_d = res_taken ? res_target : res_pc + 32'd4;
   end

   // RUN/FLUSH sequencer; flush is high for FLUSH_CYCLES cycles after a mispredict
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
         flush_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (miss_now) begin
                  state_q <= ST_FLUSH;
                  fcnt_q  <= FLUSH_LOAD;
                  flush_q <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (fcnt_q == '0) begin
                  state_q <= ST_RUN;
                  flush_q <= 1'b0;
               end else begin
                  fcnt_q <= fcnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= ST_RUN;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   // Resolution outputs, sticky error and statistics
   always_ff @(posedge clk) begin
      if (!rst) begin
         history_q    <= 1'b0;
         hist_valid_q <= 1'b0;
         mispredict_q <= 1'b0;
         redirect_q   <= '0;
         err_q        <= 1'b0;
         br_cnt_q     <= '0;
         miss_cnt_q   <= '0;
      end else begin
         hist_valid_q <= 1'b0;
         mispredict_q <= 1'b0;
         if (run && res_valid) begin
            history_q    <= res_taken;
            hist_valid_q <= 1'b1;
            br_cnt_q     <= br_cnt_d;
            if (underflow) err_q <= 1'b1;
         end
         if (miss_now) begin
            mispredict_q <= 1'b1;
            miss_cnt_q   <= miss_cnt_d;
            redirect_q   <= redirect_d;
            if (pc_bad) err_q <= 1'b1;
         end
      end
   end

   assign history     = history_q;
   assign hist_valid  = hist_valid_q;
   assign mispredict  = mispredict_q;
   assign redirect_pc = redirect_q;
   assign flush       = flush_q;
   assign err         = err_q;
   assign br_cnt      = br_cnt_q;
   assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a queue-based reference model predicts
// the registered outputs after every clock, and a monitor compares them.
module tb_branch_resolver;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned FLUSH_N = 2;
   localparam int unsigned CNT_W   = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             pred_valid;
   logic [1:0]       pred_taken;
   logic [31:0]      pred_pc;
   logic             res_valid;
   logic             res_taken;
   logic [31:0]      res_pc;
   logic [31:0]      res_target;
   logic             history;
   logic             hist_valid;
   logic             mispredict;
   logic [31:0]      redirect_pc;
   logic             flush;
   logic             q_full;
   logic             q_empty;
   logic             err;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] miss_cnt;

   branch_resolver #(
      .DEPTH        (DEPTH),
      .FLUSH_CYCLES (FLUSH_N),
      .CNT_W        (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pred_valid  (pred_valid),
      .pred_taken  (pred_taken),
      .pred_pc     (pred_pc),
      .res_valid   (res_valid),
      .res_taken   (res_taken),
      .res_pc      (res_pc),
      .res_target  (res_target),
      .history     (history),
      .hist_valid  (hist_valid),
      .mispredict  (mispredict),
      .redirect_pc (redirect_pc),
      .flush       (flush),
      .q_full      (q_full),
      .q_empty     (q_empty),
      .err         (err),
      .br_cnt      (br_cnt),
      .miss_cnt    (miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             hist;
      logic             hv;
      logic             mp;
      logic [31:0]      redir;
      logic             flush;
      logic             full;
      logic             empty;
      logic             err;
      logic [CNT_W-1:0] br;
      logic [CNT_W-1:0] miss;
   } exp_t;

   typedef struct {
      logic        dir;
      logic [31:0] pc;
   } ent_t;

   // Reference model state
   ent_t        mq[$];
   int          m_flush_left;
   logic        m_hist;
   logic [31:0] m_redir;
   logic        m_err;
   int          m_br;
   int          m_miss;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   // Monitor: one expectation per clock, compared mid-cycle
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = '{hist: history, hv: hist_valid, mp: mispredict, redir: redirect_pc,
               flush: flush, full: q_full, empty: q_empty, err: err,
               br: br_cnt, miss: miss_cnt};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d act{hist=%b hv=%b mp=%b redir=%h flush=%b full=%b empty=%b err=%b br=%0d miss=%0d} exp{hist=%b hv=%b mp=%b redir=%h flush=%b full=%b empty=%b err=%b br=%0d miss=%0d}",
                     cyc, a.hist, a.hv, a.mp, a.redir, a.flush, a.full, a.empty, a.err, a.br, a.miss,
                     e.hist, e.hv, e.mp, e.redir, e.flush, e.full, e.empty, e.err, e.br, e.miss);
         end
      end
   end

   // Apply one cycle of stimulus, advance the model, and post its expectation
   task automatic step(input logic r, input logic pv, input logic [1:0] pt,
                       input logic [31:0] ppc, input logic rv, input logic rt,
                       input logic [31:0] rpc, input logic [31:0] rtg);
      exp_t e;
      logic hv;
      logic mp;
      logic miss;
      logic was_full;
      logic did_deq;
      ent_t h;
      rst = r; pred_valid = pv; pred_taken = pt; pred_pc = ppc;
      res_valid = rv; res_taken = rt; res_pc = rpc; res_target = rtg;
      hv = 1'b0; mp = 1'b0; miss = 1'b0;
      if (!r) begin
         mq.delete();
         m_flush_left = 0; m_hist = 1'b0; m_redir = '0; m_err = 1'b0;
         m_br = 0; m_miss = 0;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
      end else begin
         was_full = (mq.size() == DEPTH);
         did_deq  = 1'b0;
         if (rv) begin
            hv = 1'b1;
            m_hist = rt;
            if (m_br < CNT_MAX) m_br++;
            if (mq.size() == 0) begin
               m_err = 1'b1;
            end else begin
               h = mq.pop_front();
               did_deq = 1'b1;
               if (h.pc != rpc) m_err = 1'b1;
               miss = (h.dir != rt) || (h.pc != rpc);
            end
            if (miss) begin
               mp = 1'b1;
               if (m_miss < CNT_MAX) m_miss++;
               m_redir = rt ? rtg : rpc + 32'd4;
               mq.delete();
               m_flush_left = FLUSH_N;
            end
         end
         if (pv && !miss && (!was_full || did_deq)) begin
            h.dir = pt[1];
            h.pc  = ppc;
            mq.push_back(h);
         end
      end
      e.hist  = m_hist;
      e.hv    = hv;
      e.mp    = mp;
      e.redir = m_redir;
      e.flush = (m_flush_left > 0);
      e.full  = (mq.size() == DEPTH);
      e.empty = (mq.size() == 0);
      e.err   = m_err;
      e.br    = CNT_W'(m_br);
      e.miss  = CNT_W'(m_miss);
      @(posedge clk);
      #1;
      cyc++;
      sb.push_back(e);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic predict(input logic [1:0] pt, input logic [31:0] pc);
      step(1'b1, 1'b1, pt, pc, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic resolve(input logic rt, input logic [31:0] pc, input logic [31:0] tgt);
      step(1'b1, 1'b0, 2'b00, '0, 1'b1, rt, pc, tgt);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic        r, pv, rv, rt;
      logic [1:0]  pt;
      logic [31:0] ppc, rpc, rtg;
      rst = 1'b0; pred_valid = 1'b0; pred_taken = '0; pred_pc = '0;
      res_valid = 1'b0; res_taken = 1'b0; res_pc = '0; res_target = '0;
      mq.delete();
      m_flush_left = 0; m_hist = 1'b0; m_redir = '0; m_err = 1'b0; m_br = 0; m_miss = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Correct prediction
      predict(2'b11, 32'h100);
      idle(); idle();
      resolve(1'b1, 32'h100, 32'h180);
      idle();

      // Predicted not-taken, actually taken; a branch offered during flush is dropped
      predict(2'b01, 32'h200);
      predict(2'b11, 32'h204);
      resolve(1'b1, 32'h200, 32'h400);
      step(1'b1, 1'b1, 2'b11, 32'h208, 1'b1, 1'b1, 32'h204, 32'h0);
      predict(2'b11, 32'h20c);
      idle(); idle();

      // Predicted taken, actually not-taken
      do_reset();
      predict(2'b10, 32'h300);
      resolve(1'b0, 32'h300, 32'h900);
      idle(); idle(); idle();

      // Fill, overflow drop, then simultaneous enqueue/dequeue while full
      predict(2'b11, 32'h600);
      predict(2'b11, 32'h604);
      predict(2'b00, 32'h608);
      predict(2'b11, 32'h60c);
      predict(2'b11, 32'h610);
      step(1'b1, 1'b1, 2'b10, 32'h614, 1'b1, 1'b1, 32'h600, 32'h0);
      resolve(1'b1, 32'h604, 32'h0);
      resolve(1'b0, 32'h608, 32'h0);
      resolve(1'b1, 32'h60c, 32'h0);
      resolve(1'b1, 32'h614, 32'h0);
      idle();

      // Underflow, then a PC desync mispredict with reset during the 2nd flush cycle
      resolve(1'b1, 32'h700, 32'h0);
      idle();
      predict(2'b11, 32'h500);
      resolve(1'b1, 32'h504, 32'h800);
      idle();
      step(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0, '0, '0);
      idle(); idle();

      // Counter saturation with 17 resolves
      for (int i = 0; i < 17; i++) resolve(1'b0, 32'h40 + 32'(i), 32'h0);
      idle();

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         r   = ($urandom_range(0, 99) != 0);
         pv  = ($urandom_range(0, 2) != 0);
         pt  = 2'($urandom_range(0, 3));
         ppc = {$urandom_range(0, 255), 2'b00};
         rv  = ($urandom_range(0, 2) == 0);
         rtg = $urandom();
         if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            rpc = mq[0].pc;
            rt  = ($urandom_range(0, 3) != 0) ? mq[0].dir : ~mq[0].dir;
         end else begin
            rpc = {$urandom_range(0, 255), 2'b00};
            rt  = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
         step(r, pv, pt, ppc, rv, rt, rpc, rtg);
      end
      idle();

      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
